// File: rtl/multi_channel_clock_divider_pkg.sv
// ============================================================================
// multi_channel_clock_divider_pkg : shared widths, reset timing, config type
// Revision 1.0
// ============================================================================
`default_nettype none

package multi_channel_clock_divider_pkg;

    localparam int c_cnt_w_default = 20;
    localparam int c_default_div   = 500000;
    localparam int c_default_high  = 250000;
    localparam int c_min_div       = 2;

    typedef logic [c_cnt_w_default-1:0] cnt_t;

    typedef struct packed {
        cnt_t div;
        cnt_t high;
    } div_cfg_t;

    // A one-cycle period has no room for both a high and a low phase.
    function automatic cnt_t clamp_div(input cnt_t div);
        return (div < cnt_t'(c_min_div)) ? cnt_t'(c_min_div) : div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_channel.sv
// ============================================================================
// clock_divider_channel : one divider with shadow/active config and tick
// Revision 1.0
// ============================================================================
`default_nettype none

module clock_divider_channel
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int CNT_W        = c_cnt_w_default,
    parameter int DEFAULT_DIV  = c_default_div,
    parameter int DEFAULT_HIGH = c_default_high
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    input  logic [CNT_W-1:0] load_high_i,
    output logic             pending_o,
    output logic             div_out_o,
    output logic             tick_o
);

    localparam div_cfg_t c_rst_cfg = '{div:  cnt_t'(DEFAULT_DIV),
                                       high: cnt_t'(DEFAULT_HIGH)};

    cnt_t     count_q,   count_d;
    div_cfg_t active_q,  active_d;
    div_cfg_t shadow_q,  shadow_d;
    logic     pending_q, pending_d;
    logic     en_q;
    logic     div_out_q, div_out_d;
    logic     tick_q,    tick_d;

    logic     w_wrap;
    logic     w_boundary;
    logic     w_apply;

    always_comb begin
        w_wrap     = en_q && (count_q == active_q.div - cnt_t'(1));
        // Any point where a fresh period begins is safe for a config swap.
        w_boundary = !en_i || !en_q || w_wrap;
        w_apply    = pending_q && w_boundary;

        active_d  = w_apply ? shadow_q : active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q && !w_apply;

        if (load_i && !pending_q) begin
            shadow_d  = '{div:  clamp_div(cnt_t'(load_div_i)),
                          high: cnt_t'(load_high_i)};
            pending_d = 1'b1;
        end

        count_d   = w_boundary ? '0 : count_q + cnt_t'(1);
        div_out_d = en_i && (count_d < active_d.high);
        tick_d    = en_i && (count_d == active_d.div - cnt_t'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= '0;
            active_q  <= c_rst_cfg;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            en_q      <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            en_q      <= en_i;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o = pending_q;
    assign div_out_o = div_out_q;
    assign tick_o    = tick_q;

endmodule

`default_nettype wire

// File: rtl/multi_channel_clock_divider.sv
// ============================================================================
// multi_channel_clock_divider : NUM_CH programmable dividers behind one load port
// Revision 1.0
// ============================================================================
`default_nettype none

module multi_channel_clock_divider
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = c_cnt_w_default,
    parameter int  DEFAULT_DIV  = c_default_div,
    parameter int  DEFAULT_HIGH = c_default_high,
    localparam int c_ch_w       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [c_ch_w-1:0] load_ch,
    input  logic [CNT_W-1:0]  load_div,
    input  logic [CNT_W-1:0]  load_high,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;

    // Unmapped channel numbers read as ready and are silently dropped.
    always_comb begin
        load_ready = 1'b1;
        w_load     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_ch == c_ch_w'(i)) begin
                load_ready = ~w_pending[i];
                w_load[i]  = load_valid & ~w_pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_HIGH (DEFAULT_HIGH)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .en_i        (ch_en[g]),
            .load_i      (w_load[g]),
            .load_div_i  (load_div),
            .load_high_i (load_high),
            .pending_o   (w_pending[g]),
            .div_out_o   (div_out[g]),
            .tick_o      (tick[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_clock_divider.sv
// ============================================================================
// tb_multi_channel_clock_divider : directed checks of the multi-channel divider
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              load_valid;
    logic              load_ready;
    logic [1:0]        load_ch;
    logic [CNT_W-1:0]  load_div;
    logic [CNT_W-1:0]  load_high;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] ed;
    logic [9:0] et;
    logic [9:0] er;
    logic [9:0] ed0;
    logic [9:0] et0;

    multi_channel_clock_divider #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (10),
        .DEFAULT_HIGH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_ch    (load_ch),
        .load_div   (load_div),
        .load_high  (load_high),
        .div_out    (div_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_req(input logic [1:0] ch, input int dv, input int hi);
        load_ch    = ch;
        load_div   = CNT_W'(dv);
        load_high  = CNT_W'(hi);
        load_valid = 1'b1;
        #1;
    endtask

    // Ten cycles of one channel against hand-written bit patterns, MSB first.
    task automatic check_seg(input string tag, input int ch, input logic [9:0] xd, input logic [9:0] xt);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("%s div_out[%0d] cyc%0d", tag, ch, j), 32'(div_out[ch]), 32'(xd[9-j]));
            check($sformatf("%s tick[%0d] cyc%0d", tag, ch, j), 32'(tick[ch]), 32'(xt[9-j]));
            step();
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] xd, input logic [9:0] xt);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("%s div_out cyc%0d", tag, j), 32'(div_out), xd[9-j] ? 32'hF : 32'h0);
            check($sformatf("%s tick cyc%0d", tag, j), 32'(tick), xt[9-j] ? 32'hF : 32'h0);
            step();
        end
    endtask

    initial begin
        rst        = 1'b0;
        ch_en      = 4'hF;
        load_valid = 1'b0;
        load_ch    = 2'd0;
        load_div   = '0;
        load_high  = '0;

        // Reset state, then default 10/5 timing on every channel from k=0.
        repeat (3) step();
        check("rst div_out", 32'(div_out), 32'h0);
        check("rst tick", 32'(tick), 32'h0);
        check("rst load_ready", 32'(load_ready), 32'h1);
        rst = 1'b1;
        step();
        check_all("default p0", 10'b1111100000, 10'b0000000001);
        check_all("default p1", 10'b1111100000, 10'b0000000001);

        // k=20: reprogram ch1 to 4/1 at count 3; old period must complete.
        repeat (3) step();
        load_req(2'd1, 4, 1);
        check("ch1 ready before load", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        ed = 10'b1000001000;
        et = 10'b0000010001;
        er = 10'b0000001111;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("reprog div_out[1] cyc%0d", j), 32'(div_out[1]), 32'(ed[9-j]));
            check($sformatf("reprog tick[1] cyc%0d", j), 32'(tick[1]), 32'(et[9-j]));
            check($sformatf("reprog load_ready cyc%0d", j), 32'(load_ready), 32'(er[9-j]));
            step();
        end

        // k=34: ch2 clamp (div 0 -> 2), then high=0, then high=div.
        load_req(2'd2, 0, 1);
        check("ch2 ready clamp", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        check_seg("clamp", 2, 10'b0000010101, 10'b0000101010);
        load_req(2'd2, 3, 0);
        step();
        load_valid = 1'b0;
        check_seg("high0", 2, 10'b1000000000, 10'b0100100100);
        load_req(2'd2, 3, 3);
        step();
        load_valid = 1'b0;
        check_seg("highdiv", 2, 10'b0001111111, 10'b0010010010);

        // k=67: back-to-back loads on ch3; second waits for the apply edge.
        load_req(2'd3, 6, 2);
        check("b2b first ready", 32'(load_ready), 32'h1);
        step();
        load_div  = CNT_W'(8);
        load_high = CNT_W'(4);
        #1;
        check("b2b held ready k68", 32'(load_ready), 32'h0);
        step();
        check("b2b held ready k69", 32'(load_ready), 32'h0);
        step();
        check("b2b ready after apply", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        #1;
        check("b2b second pending", 32'(load_ready), 32'h0);
        load_req(2'd2, 3, 3);
        check("ch2 ready while ch3 pending", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        ed  = 10'b0000111100;
        et  = 10'b0001000000;
        ed0 = 10'b1110000011;
        et0 = 10'b0000000100;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("b2b div_out[3] cyc%0d", j), 32'(div_out[3]), 32'(ed[9-j]));
            check($sformatf("b2b tick[3] cyc%0d", j), 32'(tick[3]), 32'(et[9-j]));
            check($sformatf("ch0 phase div_out cyc%0d", j), 32'(div_out[0]), 32'(ed0[9-j]));
            check($sformatf("ch0 phase tick cyc%0d", j), 32'(tick[0]), 32'(et0[9-j]));
            step();
        end

        // k=82: pending 4/2 on ch0 applied by disabling, restart on re-enable.
        load_req(2'd0, 4, 2);
        step();
        load_valid = 1'b0;
        #1;
        check("gate pending ready", 32'(load_ready), 32'h0);
        ch_en = 4'b1110;
        step();
        check("gate div_out off", 32'(div_out[0]), 32'h0);
        check("gate tick off", 32'(tick[0]), 32'h0);
        check("gate applied ready", 32'(load_ready), 32'h1);
        step();
        check("gate div_out held", 32'(div_out[0]), 32'h0);
        ch_en = 4'hF;
        step();
        check_seg("reenable", 0, 10'b1100110011, 10'b0001000100);

        // k=96: reset while ch3 has a pending load and sits at count 7.
        load_req(2'd3, 5, 5);
        check("pre-reset ready", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        #1;
        check("pre-reset pending", 32'(load_ready), 32'h0);
        step();
        step();
        check("ch3 count7 div_out", 32'(div_out[3]), 32'h0);
        rst = 1'b0;
        step();
        check("midrst div_out", 32'(div_out), 32'h0);
        check("midrst tick", 32'(tick), 32'h0);
        check("midrst ready", 32'(load_ready), 32'h1);
        rst = 1'b1;
        step();
        check_all("after midrst", 10'b1111100000, 10'b0000000001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the single fixed-period divider.
- NUM_CH independent channels. Each has a runtime-programmable period and high time (duty cycle), a per-channel enable, and a one-cycle end-of-period tick.
- Configuration uses a valid/ready load port. New settings apply only at a period boundary, so outputs never glitch.
- Sits between the board clock and the display-scan, debounce and slow-FSM blocks that need derived rates.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 20, counter/period register width in bits.
- DEFAULT_DIV, 500000, reset period in clk cycles for every channel (must fit in CNT_W).
- DEFAULT_HIGH, 250000, reset high time in clk cycles for every channel.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- load_valid  in  1  configuration request.
- load_ready  out  1  block can accept a request for load_ch.
- load_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- load_div  in  CNT_W  requested period in cycles.
- load_high  in  CNT_W  requested high time in cycles.
- div_out  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-cycle pulse in the last cycle of each period, registered.

Behaviour:
- Reset: synchronous, active-low; clk and reset are the only timing inputs. When rst is sampled low, on that edge:
  - every count = 0
  - active_div = DEFAULT_DIV, active_high = DEFAULT_HIGH
  - pending = 0, shadow registers = 0
  - div_out = 0, tick = 0
  - load_ready = 1 at the first cycle after rst is released.
- Counter: per channel, count runs 0..active_div-1 and then wraps to 0. No terminal overshoot; the wrap is exact.
- div_out: div_out[i] = 1 in exactly the cycles where ch_en was high on the previous edge and count < active_high.
  - active_high = 0 gives a constant-low output.
  - active_high >= active_div gives a constant-high output.
- tick: tick[i] = 1 in exactly the cycle where count == active_div-1 and the channel is running.
- Period clamp: active_div < 2 is clamped to 2 at load. Widths are unsigned with no overflow; compares are CNT_W bits.
- Enable low:
  - count held at 0; div_out = 0 and tick = 0 on the next edge.
  - A pending configuration is copied into active immediately.
- Enable rising (sampled at edge t): count = 0 at t+1, and div_out = 1 at t+1 if active_high > 0.
  - Period 0 starts aligned to enable; there is no residual phase from before.
- Load handshake:
  - load_ready = ~pending[load_ch] (combinational on load_ch).
  - A transfer occurs when load_valid && load_ready at a rising edge: shadow[load_ch] <= {load_div, load_high} (clamped) and pending[load_ch] <= 1.
  - A request with load_ready low is not accepted; the requester holds it.
- Apply: at the edge where a running channel wraps (tick cycle), active <= shadow and pending clears. The new period starts with count = 0 using the new values.
- Simultaneous load and apply on the same channel:
  - The apply uses the old shadow.
  - The load is refused because pending is still 1 in that cycle.
  - The requester retries next cycle and is accepted then.
- Reset mid-period or mid-handshake: all state, including pending and shadow, is discarded and default timing resumes.
- Channels are fully independent; loads to channel i never disturb the phase of channel j.

Decomposition:
- Shared package holds:
  - the default CNT_W and DEFAULT_DIV/DEFAULT_HIGH constants
  - a clamp function (div < 2 gives 2)
  - a config struct {div, high} used for both shadow and active registers.
- One natural sub-module: clock_divider_channel, containing the counter, active/shadow registers, the pending flag and output decode. It is instantiated NUM_CH times by a generate loop.
- The top level contains only load_ch decode, load_ready muxing and the generate loop.

Test Plan:
- Reset default: rst=0 for 3 cycles, then 1 with all ch_en=1 and DEFAULT_DIV overridden to 10, DEFAULT_HIGH to 5 -> each div_out is 5 high / 5 low, tick every 10th cycle, first div_out=1 one cycle after enable.
- Runtime reprogram: ch1 running DIV=10; load {div=4, high=1} mid-period -> load_ready[ch1] drops; old 10-cycle period completes; next period is 1 high, 3 low; load_ready returns 1 after the tick cycle.
- Clamp and extremes: load div=0, high=1 -> period 2, output toggles every cycle. load high=0 -> div_out constant 0 with ticks continuing. load high=DIV -> div_out constant 1.
- Back-to-back loads: second load_valid to the same channel while pending -> not accepted until the apply edge; accepted the following cycle. Meanwhile a load to ch2 is accepted immediately and ch0 phase is unchanged.
- Enable gating: ch_en[0] low mid-period with a pending config -> div_out[0]=0 next cycle, config applied immediately; re-enable -> count restarts at 0 with the new period.
- Reset mid-operation: assert rst during a pending load and count=7 -> next cycle all outputs 0, pending cleared, defaults restored.
